d_out_arbiter: RTL and testbench
================================

# d_out_arbiter

Downstream consumer of the two destination FIFOs, `fifo_d0` and `fifo_d1`. It pops both FIFOs with round-robin fairness, absorbing their one-cycle registered read latency. Popped words go into a 2-entry output queue and leave on a valid/ready port toward the output stage. It never pops an empty FIFO and never drops a word, and it keeps per-destination word counters.

## Interface
Parameters:
- `DATA_SIZE`, 6: word width; matches `fifo_d0`/`fifo_d1`.
- `CNT_W`, 8: width of the per-destination word counters.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `fifo_empty_d0_cond`  in  1  d0 FIFO empty flag.
- `fifo_empty_d1_cond`  in  1  d1 FIFO empty flag.
- `data_out_0_cond`  in  DATA_SIZE  d0 FIFO registered read data.
- `data_out_1_cond`  in  DATA_SIZE  d1 FIFO registered read data.
- `pop_d0`  out  1  pop request to d0 FIFO (combinational).
- `pop_d1`  out  1  pop request to d1 FIFO (combinational).
- `out_ready`  in  1  downstream accepts the head word this cycle.
- `out_valid`  out  1  head of the output queue is valid.
- `out_data`  out  DATA_SIZE  head word.
- `out_dest`  out  1  source of the head word: 0 = d0, 1 = d1.
- `cnt_d0`  out  CNT_W  words delivered from d0, wrapping.
- `cnt_d1`  out  CNT_W  words delivered from d1, wrapping.
- `arb_idle`  out  1  high when the FSM is in IDLE.

## Operation
- **Read latency:** a pop asserted in cycle N makes the FIFO data valid on `data_out_X_cond` during cycle N+1. The arbiter captures it at the end of N+1, when `inflight` = 1.
- **State:** `inflight` (1 bit), `inflight_src` (1 bit), `occ` (0..2, the output queue occupancy), `last_grant` (1 bit).
- **Dequeue:** `deq = out_valid & out_ready`.
- **Pop permission:** `can_pop = (occ + inflight - deq) < 2`. The path from `out_ready` to `pop_dX` is combinational by design.
- **Request:** `req0 = ~fifo_empty_d0_cond`, `req1 = ~fifo_empty_d1_cond`.
- **Grant:** when `can_pop` is high, grant as follows and update `last_grant`:
  - Both requesting: grant the source ≠ `last_grant`.
  - One requesting: grant it.
- **Pop outputs:** at most one of `pop_d0`/`pop_d1` is high in any cycle.
- **Capture:** when `inflight` is high, the word is enqueued from `inflight_src` at the end of the cycle. `cnt_d0` or `cnt_d1` increments by 1 (mod 2^CNT_W) on dequeue of a word with that `out_dest`.
- **Simultaneous enqueue and dequeue:** `occ` is unchanged. The queue must never overflow; a capture with `occ` = 2 and no dequeue is a design error and is asserted against in simulation.
- **FSM states:**
  - INIT: first cycle after reset release. Pops are disabled; the FSM moves to IDLE unconditionally.
  - IDLE: `occ` = 0, `inflight` = 0, no request. A request moves it to ACTIVE.
  - ACTIVE: moves back to IDLE when `occ` = 0, `inflight` = 0 and the pop-free condition holds.
- **Reset mid-operation:** the in-flight word is discarded and the queue cleared. The FIFOs reset concurrently, so no word is lost.

## Timing
- **Reset values:** `pop_d0`/`pop_d1` 0, `out_valid` 0, `out_data` 0, `out_dest` 0, `cnt_d0`/`cnt_d1` 0, `arb_idle` 0 (INIT). Internal: `last_grant` = 1, so d0 wins the first tie; `occ` = 0, `inflight` = 0.
- **Latency:** pop in cycle N → `out_valid` high in cycle N+2 with that word, provided the queue was empty.
- **Throughput:** one word per cycle sustained with `out_ready` held high.
- **Handshake:** while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_dest` hold stable. Order is FIFO across both sources, in pop order.
- **Empty flags:** sampled the cycle the pop is decided. The FIFO updates its empty flag at the pop edge, so back-to-back pops of a 1-entry FIFO cannot occur.

## Structure
- **Shared package `d_arb_pkg`:** FSM state typedef (INIT, IDLE, ACTIVE), `DATA_SIZE` default, source encoding constants `SRC_D0` = 0 and `SRC_D1` = 1.
- **Sub-module `out_q2`:** 2-entry FIFO of {dest, data} with `enq`/`deq`/`occ`, head registers driving `out_data`/`out_dest`.
- **Top level:** grant logic, in-flight tracking, FSM and counters stay here.

## Test plan
- **Single word:** d0 holds 0x2A, d1 empty, `out_ready` = 1 → `pop_d0` high one cycle after INIT. Two cycles later `out_valid` = 1, `out_data` = 0x2A, `out_dest` = 0, then `cnt_d0` = 1, then `arb_idle` = 1.
- **Fairness:** d0 and d1 each hold 4 words, `out_ready` = 1 → output dest sequence 0,1,0,1,0,1,0,1, one word per cycle after the first, with `cnt_d0` = `cnt_d1` = 4.
- **Backpressure:** 3 words in d1, `out_ready` = 0 → exactly 2 pops occur. `out_data` holds word 1 stable. After `out_ready` = 1 all 3 words exit in order and no pop ever hits an empty FIFO.
- **Ready toggling:** `out_ready` toggles every cycle over 10 d0 words → all 10 delivered in order, `occ` never exceeds 2.
- **Reset mid-flight:** `reset_L` asserted with `inflight` = 1 and `occ` = 2 → all outputs return to their reset values immediately (asynchronously). After release, one INIT cycle precedes any pop.
- **Counter wrap:** 257 d1 words delivered → `cnt_d1` = 1.

Source files
------------

// File: rtl/d_arb_pkg.sv
// Shared types and constants for the destination-FIFO output arbiter.
package d_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_e;

  localparam int   DATA_SIZE_DEF = 6;
  localparam logic SRC_D0        = 1'b0;
  localparam logic SRC_D1        = 1'b1;

endpackage

// File: rtl/d_out_arbiter_out_q2.sv
// Two-entry output queue of {dest, data}; slot0 is always the head.
module out_q2 #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq,
  input  logic         deq,
  input  logic [W-1:0] enq_entry,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   occ_q, occ_d;
  logic [1:0]   occ_after;

  always_comb begin
    occ_after = occ_q - {1'b0, deq};
    slot0_d   = deq ? slot1_q : slot0_q;
    slot1_d   = slot1_q;
    occ_d     = occ_after + {1'b0, enq};
    // The incoming word lands in the first free slot after the head shift.
    if (enq) begin
      if (occ_after == 2'd0) slot0_d = enq_entry;
      else                   slot1_d = enq_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign head = slot0_q;
  assign occ  = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(enq && !deq && occ_q == 2'd2));

endmodule

// File: rtl/d_out_arbiter.sv
// Round-robin popper for fifo_d0/fifo_d1 feeding a valid/ready output port.
//   state  | meaning
//   INIT   | first cycle after reset, pops disabled
//   IDLE   | queue empty, nothing in flight, no request
//   ACTIVE | words being popped, in flight or queued
module d_out_arbiter
  import d_arb_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 fifo_empty_d0_cond,
  input  logic                 fifo_empty_d1_cond,
  input  logic [DATA_SIZE-1:0] data_out_0_cond,
  input  logic [DATA_SIZE-1:0] data_out_1_cond,
  output logic                 pop_d0,
  output logic                 pop_d1,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_dest,
  output logic [CNT_W-1:0]     cnt_d0,
  output logic [CNT_W-1:0]     cnt_d1,
  output logic                 arb_idle
);

  arb_state_e         state_q, state_d;
  logic               inflight_q, inflight_d;
  logic               inflight_src_q, inflight_src_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_d0_q, cnt_d0_d;
  logic [CNT_W-1:0]   cnt_d1_q, cnt_d1_d;
  logic               arb_idle_q, arb_idle_d;

  logic               req0, req1, grant0, grant1, can_pop, deq;
  logic [2:0]         pipe_cnt;
  logic [1:0]         occ;
  logic [DATA_SIZE:0] enq_entry, head;

  assign out_valid = (occ != 2'd0);
  assign deq       = out_valid & out_ready;
  assign enq_entry = {inflight_src_q,
                      (inflight_src_q == SRC_D1) ? data_out_1_cond : data_out_0_cond};

  always_comb begin
    req0     = ~fifo_empty_d0_cond;
    req1     = ~fifo_empty_d1_cond;
    // Words already queued or in flight, less the one leaving this cycle.
    pipe_cnt = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, deq};
    can_pop  = (state_q != ST_INIT) && (pipe_cnt < 3'd2);
    grant0   = can_pop & req0 & (~req1 | (last_grant_q == SRC_D1));
    grant1   = can_pop & req1 & (~req0 | (last_grant_q == SRC_D0));

    inflight_d     = grant0 | grant1;
    inflight_src_d = grant1 ? SRC_D1 : SRC_D0;
    last_grant_d   = last_grant_q;
    if (grant0 | grant1) last_grant_d = grant1 ? SRC_D1 : SRC_D0;

    cnt_d0_d = cnt_d0_q;
    cnt_d1_d = cnt_d1_q;
    if (deq && out_dest == SRC_D0) cnt_d0_d = cnt_d0_q + 1'b1;
    if (deq && out_dest == SRC_D1) cnt_d1_d = cnt_d1_q + 1'b1;

    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (req0 | req1) state_d = ST_ACTIVE;
      ST_ACTIVE: if (occ == 2'd0 && !inflight_q && !(grant0 | grant1)) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
    arb_idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q        <= ST_INIT;
      inflight_q     <= 1'b0;
      inflight_src_q <= SRC_D0;
      last_grant_q   <= SRC_D1;
      cnt_d0_q       <= '0;
      cnt_d1_q       <= '0;
      arb_idle_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      inflight_q     <= inflight_d;
      inflight_src_q <= inflight_src_d;
      last_grant_q   <= last_grant_d;
      cnt_d0_q       <= cnt_d0_d;
      cnt_d1_q       <= cnt_d1_d;
      arb_idle_q     <= arb_idle_d;
    end
  end

  out_q2 #(.W(DATA_SIZE + 1)) u_out_q2 (
    .clk       (clk),
    .rst_n     (reset_L),
    .enq       (inflight_q),
    .deq       (deq),
    .enq_entry (enq_entry),
    .head      (head),
    .occ       (occ)
  );

  assign out_data = head[DATA_SIZE-1:0];
  assign out_dest = head[DATA_SIZE];
  assign pop_d0   = grant0;
  assign pop_d1   = grant1;
  assign cnt_d0   = cnt_d0_q;
  assign cnt_d1   = cnt_d1_q;
  assign arb_idle = arb_idle_q;

endmodule

// File: tb/tb_d_out_arbiter.sv
// Directed bench for d_out_arbiter with behavioural models of fifo_d0/fifo_d1.
module tb_d_out_arbiter;
  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          fifo_empty_d0_cond, fifo_empty_d1_cond;
  logic [DW-1:0] data_out_0_cond, data_out_1_cond;
  logic          pop_d0, pop_d1, out_ready, out_valid, out_dest, arb_idle;
  logic [DW-1:0] out_data;
  logic [CW-1:0] cnt_d0, cnt_d1;

  d_out_arbiter #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
    .clk                (clk),
    .reset_L            (reset_L),
    .fifo_empty_d0_cond (fifo_empty_d0_cond),
    .fifo_empty_d1_cond (fifo_empty_d1_cond),
    .data_out_0_cond    (data_out_0_cond),
    .data_out_1_cond    (data_out_1_cond),
    .pop_d0             (pop_d0),
    .pop_d1             (pop_d1),
    .out_ready          (out_ready),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_dest           (out_dest),
    .cnt_d0             (cnt_d0),
    .cnt_d1             (cnt_d1),
    .arb_idle           (arb_idle)
  );

  always #5 clk = ~clk;

  // FIFO models: registered read data, empty flag updates at the pop edge.
  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

  assign fifo_empty_d0_cond = (rd0 == wr0);
  assign fifo_empty_d1_cond = (rd1 == wr1);

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd0 <= wr0;
      rd1 <= wr1;
      data_out_0_cond <= '0;
      data_out_1_cond <= '0;
    end else begin
      if (pop_d0 && rd0 != wr0) begin
        data_out_0_cond <= mem0[rd0 % 1024];
        rd0 <= rd0 + 1;
      end
      if (pop_d1 && rd1 != wr1) begin
        data_out_1_cond <= mem1[rd1 % 1024];
        rd1 <= rd1 + 1;
      end
    end
  end

  // Delivery and pop monitor, sampled mid-cycle.
  logic [DW-1:0] log_data [1024];
  logic          log_dest [1024];
  int            log_cyc  [1024];
  int cyc = 0, n_out = 0, n_pop0 = 0, n_pop1 = 0, n_bad_pop = 0, n_both = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_L) begin
      if (out_valid && out_ready && n_out < 1024) begin
        log_data[n_out] <= out_data;
        log_dest[n_out] <= out_dest;
        log_cyc[n_out]  <= cyc;
        n_out <= n_out + 1;
      end
      if (pop_d0) n_pop0 <= n_pop0 + 1;
      if (pop_d1) n_pop1 <= n_pop1 + 1;
      if ((pop_d0 && rd0 == wr0) || (pop_d1 && rd1 == wr1)) n_bad_pop <= n_bad_pop + 1;
      if (pop_d0 && pop_d1) n_both <= n_both + 1;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load0(input logic [DW-1:0] v);
    mem0[wr0 % 1024] = v;
    wr0++;
  endtask

  task automatic load1(input logic [DW-1:0] v);
    mem1[wr1 % 1024] = v;
    wr1++;
  endtask

  task automatic start_reset;
    @(posedge clk);
    #1;
    reset_L   = 1'b0;
    out_ready = 1'b0;
    tick(2);
  endtask

  task automatic wait_out(input int target, input int budget, input string tag);
    int k = 0;
    while (n_out < target && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_done"}, 32'(n_out >= target), 1);
  endtask

  int base, p1;

  initial begin
    reset_L   = 1'b0;
    out_ready = 1'b0;
    tick(2);
    chk("rst_pop_d0", pop_d0, 0);
    chk("rst_pop_d1", pop_d1, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_cnt_d0", cnt_d0, 0);
    chk("rst_cnt_d1", cnt_d1, 0);
    chk("rst_idle", arb_idle, 0);

    // Single word through d0.
    reset_L = 1'b1;
    load0(6'h2A);
    out_ready = 1'b1;
    @(negedge clk);
    chk("init_no_pop", pop_d0, 0);
    chk("init_idle", arb_idle, 0);
    @(negedge clk);
    chk("single_pop_d0", pop_d0, 1);
    chk("single_pop_d1", pop_d1, 0);
    @(negedge clk);
    chk("single_lat_nv", out_valid, 0);
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'h2A);
    chk("single_dest", out_dest, 0);
    @(negedge clk);
    chk("single_cnt_d0", cnt_d0, 1);
    chk("single_drained", out_valid, 0);
    chk("single_active", arb_idle, 0);
    @(negedge clk);
    chk("single_idle", arb_idle, 1);

    // Fairness with both FIFOs full of 4 words.
    start_reset();
    reset_L = 1'b1;
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      load0(6'h10 + 6'(i));
      load1(6'h20 + 6'(i));
    end
    out_ready = 1'b1;
    wait_out(base + 8, 40, "fair");
    for (int i = 0; i < 8; i++) begin
      chk("fair_dest", log_dest[base + i], 32'(i % 2));
      chk("fair_data", log_data[base + i], (i % 2 == 1) ? 32'h20 + 32'(i / 2) : 32'h10 + 32'(i / 2));
    end
    for (int i = 1; i < 8; i++)
      chk("fair_rate", log_cyc[base + i] - log_cyc[base + i - 1], 1);
    tick(2);
    chk("fair_cnt_d0", cnt_d0, 4);
    chk("fair_cnt_d1", cnt_d1, 4);

    // Backpressure: three d1 words with out_ready low.
    start_reset();
    reset_L = 1'b1;
    base = n_out;
    p1 = n_pop1;
    load1(6'h31);
    load1(6'h32);
    load1(6'h33);
    tick(8);
    chk("bp_two_pops", n_pop1 - p1, 2);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 32'h31);
    chk("bp_dest", out_dest, 1);
    tick(3);
    chk("bp_hold", out_data, 32'h31);
    out_ready = 1'b1;
    wait_out(base + 3, 20, "bp");
    for (int i = 0; i < 3; i++)
      chk("bp_order", log_data[base + i], 32'h31 + 32'(i));
    tick(1);
    chk("bp_all_pops", n_pop1 - p1, 3);

    // out_ready toggling every cycle over 10 d0 words.
    start_reset();
    reset_L = 1'b1;
    base = n_out;
    for (int i = 0; i < 10; i++) load0(6'((7 + i * 5) % 64));
    for (int k = 0; k < 80 && n_out < base + 10; k++) begin
      tick(1);
      out_ready = ~out_ready;
    end
    chk("tog_done", 32'(n_out >= base + 10), 1);
    for (int i = 0; i < 10; i++) begin
      chk("tog_data", log_data[base + i], 32'((7 + i * 5) % 64));
      chk("tog_dest", log_dest[base + i], 0);
    end
    out_ready = 1'b1;
    tick(3);
    chk("tog_cnt_d0", cnt_d0, 10);

    // Reset asserted while the queue is full.
    start_reset();
    reset_L = 1'b1;
    load1(6'h01);
    load1(6'h02);
    load1(6'h03);
    tick(6);
    chk("mid_valid", out_valid, 1);
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_dest", out_dest, 0);
    chk("mid_rst_pop1", pop_d1, 0);
    chk("mid_rst_idle", arb_idle, 0);
    tick(1);
    reset_L = 1'b1;
    base = n_out;
    load0(6'h15);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_init_no_pop", pop_d0, 0);
    @(negedge clk);
    chk("mid_pop_d0", pop_d0, 1);
    wait_out(base + 1, 10, "mid");
    chk("mid_word", log_data[base], 32'h15);

    // Counter wrap on d1.
    start_reset();
    reset_L = 1'b1;
    base = n_out;
    for (int i = 0; i < 257; i++) load1(6'(i % 64));
    out_ready = 1'b1;
    wait_out(base + 257, 400, "wrap");
    tick(3);
    chk("wrap_cnt_d1", cnt_d1, 1);
    chk("wrap_cnt_d0", cnt_d0, 0);
    chk("wrap_word200", log_data[base + 200], 32'(200 % 64));
    chk("wrap_last", log_data[base + 256], 0);

    chk("no_empty_pop", n_bad_pop, 0);
    chk("never_both_pops", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
